fetch_ctrl: RTL and testbench

//  Sequencer for the 5-stage fetch stage: drives PC write-enable and PC-source select, holds the
//  IF/ID register, and flushes IF/ID and ID/EX bubbles.

---
 rtl/fetch_ctrl_pkg.sv | 13 +
 rtl/fetch_ctrl_if.sv | 28 ++
 rtl/fetch_ctrl_sat_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch-stage sequencer: FSM states, PC-source select values, NOP word.
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      WAIT  = 2'd2,
      FLUSH = 2'd3
   } fetch_state_e;

   localparam logic        PC_SEL_SEQ   = 1'b0;
   localparam logic        PC_SEL_REDIR = 1'b1;
   localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch sequencer (master) and the IF datapath / hazard logic (slave).
interface fetch_ctrl_if;
   logic        is_bj;
   logic [31:0] bj_addr;
   logic        load_use;
   logic        im_ready;
   logic        pc_we;
   logic        pc_sel;
   logic [31:0] redirect_addr;
   logic        ifid_we;
   logic        ifid_flush;
   logic        idex_flush;
   logic        fetch_valid;
   logic [31:0] stall_cycles;
   logic [31:0] redirect_count;

   modport master (
      input  is_bj, bj_addr, load_use, im_ready,
      output pc_we, pc_sel, redirect_addr, ifid_we, ifid_flush, idex_flush, fetch_valid,
      output stall_cycles, redirect_count
   );

   modport slave (
      output is_bj, bj_addr, load_use, im_ready,
      input  pc_we, pc_sel, redirect_addr, ifid_we, ifid_flush, idex_flush, fetch_valid,
      input  stall_cycles, redirect_count
   );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// 32-bit (default) saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) cnt_q <= cnt_d;

   assign cnt_o = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC enable/select, IF/ID hold, IF/ID + ID/EX bubbles, boot hold-off.
// Perf counters are built only when FETCH_CTRL_PERF_EN is defined; otherwise the ports read 0.
module fetch_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          BOOT_HOLD     = 4,
   parameter int          FLUSH_BUBBLES = 1
) (
   input  logic          clk,
   input  logic          reset,
   fetch_ctrl_if.master  bus
);
   localparam logic [3:0] BOOT_LAST  = 4'(BOOT_HOLD - 1);
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_BUBBLES - 1);

   fetch_state_e state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         pend_q, pend_d;
   logic [31:0]  pend_addr_q, pend_addr_d;

   logic        pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, fetch_valid, run_rules;
   logic [31:0] redir;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pc_we       = 1'b0;
      pc_sel      = PC_SEL_SEQ;
      redir       = pend_addr_q;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      fetch_valid = 1'b0;
      run_rules   = 1'b0;

      unique case (state_q)
         BOOT: begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            redir      = RESET_PC;
            if (cnt_q == BOOT_LAST) begin
               pc_we   = 1'b1;
               pc_sel  = PC_SEL_REDIR;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RUN: run_rules = 1'b1;
         WAIT: begin
            if (bus.is_bj || (bus.im_ready && !pend_q)) begin
               run_rules = 1'b1;
            end else if (!bus.im_ready) begin
               ifid_flush = 1'b1;
            end else begin
               // memory returned with a redirect parked: issue it now
               pc_we      = 1'b1;
               pc_sel     = PC_SEL_REDIR;
               redir      = pend_addr_q;
               ifid_flush = 1'b1;
               pend_d     = 1'b0;
               cnt_d      = FLUSH_LOAD;
               state_d    = (FLUSH_BUBBLES > 1) ? FLUSH : RUN;
            end
         end
         FLUSH: begin
            if (bus.is_bj) begin
               run_rules = 1'b1;
            end else begin
               ifid_flush = 1'b1;
               pc_we      = bus.im_ready;
               cnt_d      = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
               if (cnt_q <= 4'd1) state_d = RUN;
            end
         end
         default: state_d = BOOT;
      endcase

      if (run_rules) begin
         state_d = RUN;
         if (bus.is_bj && bus.im_ready) begin
            pc_we      = 1'b1;
            pc_sel     = PC_SEL_REDIR;
            redir      = bus.bj_addr;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pend_d     = 1'b0;
            cnt_d      = FLUSH_LOAD;
            if (FLUSH_BUBBLES > 1) state_d = FLUSH;
         end else if (bus.is_bj) begin
            pend_d      = 1'b1;
            pend_addr_d = bus.bj_addr;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            state_d     = WAIT;
         end else if (!bus.im_ready) begin
            ifid_flush = 1'b1;
            state_d    = WAIT;
         end else if (bus.load_use) begin
            idex_flush  = 1'b1;
            fetch_valid = 1'b1;
         end else begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            fetch_valid = 1'b1;
         end
      end

      if (reset) begin
         pc_we       = 1'b0;
         pc_sel      = PC_SEL_SEQ;
         redir       = RESET_PC;
         ifid_we     = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         fetch_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= BOOT;
         cnt_q       <= 4'd0;
         pend_q      <= 1'b0;
         pend_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   assign bus.pc_we         = pc_we;
   assign bus.pc_sel        = pc_sel;
   assign bus.redirect_addr = redir;
   assign bus.ifid_we       = ifid_we;
   assign bus.ifid_flush    = ifid_flush;
   assign bus.idex_flush    = idex_flush;
   assign bus.fetch_valid   = fetch_valid;

`ifdef FETCH_CTRL_PERF_EN
   logic stall_inc, redir_inc;
   assign stall_inc = !reset && (state_q != BOOT) && !pc_we;
   assign redir_inc = !reset && (state_q != BOOT) && pc_we && (pc_sel == PC_SEL_REDIR);

   sat_counter #(.W(32)) u_stall_cnt (
      .clk   (clk),
      .clr_i (reset),
      .inc_i (stall_inc),
      .cnt_o (bus.stall_cycles)
   );

   sat_counter #(.W(32)) u_redir_cnt (
      .clk   (clk),
      .clr_i (reset),
      .inc_i (redir_inc),
      .cnt_o (bus.redirect_count)
   );
`else
   assign bus.stall_cycles   = 32'h0;
   assign bus.redirect_count = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (BOOT_HOLD=4, FLUSH_BUBBLES=2); perf expectations follow FETCH_CTRL_PERF_EN.
module tb_fetch_ctrl;
   import pipe_ctrl_pkg::*;

`ifdef FETCH_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   passed = 0;
   int   total  = 0;

   fetch_ctrl_if bus ();

   fetch_ctrl #(
      .RESET_PC      (32'h0000_0000),
      .BOOT_HOLD     (4),
      .FLUSH_BUBBLES (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // drive on the falling edge, let the combinational outputs settle, then check
   task automatic step(input logic rst, input logic bj, input logic [31:0] a,
                       input logic lu, input logic rdy);
      @(negedge clk);
      reset        = rst;
      bus.is_bj    = bj;
      bus.bj_addr  = a;
      bus.load_use = lu;
      bus.im_ready = rdy;
      #1;
   endtask

   task automatic boot_seq(input string tag);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 32'h0, 0, 1);
         chk({tag, "_boot_pcwe"}, 32'(bus.pc_we), 0);
         chk({tag, "_boot_ifflush"}, 32'(bus.ifid_flush), 1);
      end
      step(0, 0, 32'h0, 0, 1);
      chk({tag, "_boot_last_pcwe"}, 32'(bus.pc_we), 1);
      chk({tag, "_boot_last_pcsel"}, 32'(bus.pc_sel), 1);
      chk({tag, "_boot_last_addr"}, bus.redirect_addr, 32'h0);
      chk({tag, "_boot_last_ifflush"}, 32'(bus.ifid_flush), 1);
      step(0, 0, 32'h0, 0, 1);
      chk({tag, "_run_valid"}, 32'(bus.fetch_valid), 1);
      chk({tag, "_run_pcsel"}, 32'(bus.pc_sel), 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.is_bj = 1'b0; bus.bj_addr = 32'h0; bus.load_use = 1'b0; bus.im_ready = 1'b1;

      // 1: reset held 3 cycles, then boot hold-off
      step(1, 0, 32'h0, 0, 1);
      chk("rst_pcwe", 32'(bus.pc_we), 0);
      chk("rst_ifflush", 32'(bus.ifid_flush), 1);
      chk("rst_idexflush", 32'(bus.idex_flush), 1);
      chk("rst_addr", bus.redirect_addr, 32'h0);
      step(1, 0, 32'h0, 0, 1);
      step(1, 0, 32'h0, 0, 1);
      chk("rst_state", 32'(dut.state_q), 32'(BOOT));
      boot_seq("t1");
      chk("t1_ifwe", 32'(bus.ifid_we), 1);
      chk("t1_stall0", bus.stall_cycles, 32'h0);

      // 2: taken branch, two flush bubbles
      step(0, 1, 32'h40, 0, 1);
      chk("t2_pcwe", 32'(bus.pc_we), 1);
      chk("t2_pcsel", 32'(bus.pc_sel), 1);
      chk("t2_addr", bus.redirect_addr, 32'h40);
      chk("t2_idex", 32'(bus.idex_flush), 1);
      chk("t2_ifflush0", 32'(bus.ifid_flush), 1);
      step(0, 0, 32'h0, 0, 1);
      chk("t2_ifflush1", 32'(bus.ifid_flush), 1);
      chk("t2_flush_valid", 32'(bus.fetch_valid), 0);
      chk("t2_flush_pcsel", 32'(bus.pc_sel), 0);
      step(0, 0, 32'h0, 0, 1);
      chk("t2_run_ifflush", 32'(bus.ifid_flush), 0);
      chk("t2_run_valid", 32'(bus.fetch_valid), 1);
      chk("t2_redir_cnt", bus.redirect_count, PERF ? 32'd1 : 32'd0);

      // 3: load-use stall for exactly 2 cycles
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 32'h0, 1, 1);
         chk("t3_pcwe", 32'(bus.pc_we), 0);
         chk("t3_ifwe", 32'(bus.ifid_we), 0);
         chk("t3_idex", 32'(bus.idex_flush), 1);
         chk("t3_ifflush", 32'(bus.ifid_flush), 0);
      end
      step(0, 0, 32'h0, 0, 1);
      chk("t3_release_pcwe", 32'(bus.pc_we), 1);
      chk("t3_release_idex", 32'(bus.idex_flush), 0);
      chk("t3_stall_cnt", bus.stall_cycles, PERF ? 32'd2 : 32'd0);

      // 4: memory wait with two redirects; the last one wins
      step(0, 0, 32'h0, 0, 0);
      chk("t4_wait_pcwe", 32'(bus.pc_we), 0);
      chk("t4_wait_ifflush", 32'(bus.ifid_flush), 1);
      chk("t4_wait_valid", 32'(bus.fetch_valid), 0);
      step(0, 1, 32'h80, 0, 0);
      chk("t4_bj1_pcwe", 32'(bus.pc_we), 0);
      step(0, 1, 32'hC0, 0, 0);
      chk("t4_bj2_pcwe", 32'(bus.pc_we), 0);
      chk("t4_pend", 32'(dut.pend_q), 1);
      step(0, 0, 32'h0, 0, 1);
      chk("t4_rdy_pcwe", 32'(bus.pc_we), 1);
      chk("t4_rdy_pcsel", 32'(bus.pc_sel), 1);
      chk("t4_rdy_addr", bus.redirect_addr, 32'hC0);
      chk("t4_cnt_before", bus.redirect_count, PERF ? 32'd1 : 32'd0);
      step(0, 0, 32'h0, 0, 1);
      chk("t4_cnt_after", bus.redirect_count, PERF ? 32'd2 : 32'd0);
      chk("t4_flush", 32'(bus.ifid_flush), 1);
      step(0, 0, 32'h0, 0, 1);
      chk("t4_run_valid", 32'(bus.fetch_valid), 1);

      // 5: branch beats load-use, then re-armed mid-flush
      step(0, 1, 32'h100, 1, 1);
      chk("t5_pcwe", 32'(bus.pc_we), 1);
      chk("t5_addr", bus.redirect_addr, 32'h100);
      chk("t5_ifwe", 32'(bus.ifid_we), 0);
      step(0, 1, 32'h200, 0, 1);
      chk("t5_rearm_pcsel", 32'(bus.pc_sel), 1);
      chk("t5_rearm_addr", bus.redirect_addr, 32'h200);
      chk("t5_rearm_idex", 32'(bus.idex_flush), 1);
      step(0, 0, 32'h0, 0, 1);
      chk("t5_flush_again", 32'(bus.ifid_flush), 1);
      chk("t5_flush_valid", 32'(bus.fetch_valid), 0);
      step(0, 0, 32'h0, 0, 1);
      chk("t5_run_valid", 32'(bus.fetch_valid), 1);

      // 6a: reset mid-FLUSH
      step(0, 1, 32'h300, 0, 1);
      step(1, 0, 32'h0, 0, 1);
      chk("t6_flush_state", 32'(dut.state_q), 32'(FLUSH));
      chk("t6_rst_pcwe", 32'(bus.pc_we), 0);
      step(1, 0, 32'h0, 0, 1);
      chk("t6a_state", 32'(dut.state_q), 32'(BOOT));
      chk("t6a_redir_cnt", bus.redirect_count, 32'h0);
      chk("t6a_stall_cnt", bus.stall_cycles, 32'h0);
      boot_seq("t6a");

      // 6b: reset mid-WAIT with a parked redirect
      step(0, 0, 32'h0, 0, 0);
      step(0, 1, 32'h400, 0, 0);
      step(1, 0, 32'h0, 0, 0);
      chk("t6b_pend_before", 32'(dut.pend_q), 1);
      step(1, 0, 32'h0, 0, 1);
      chk("t6b_state", 32'(dut.state_q), 32'(BOOT));
      chk("t6b_pend", 32'(dut.pend_q), 0);
      chk("t6b_redir_cnt", bus.redirect_count, 32'h0);
      boot_seq("t6b");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
